// File: rtl/parity_ctrl_pkg.sv
// Shared types and line-level constants for the parity serial controller.
package parity_ctrl_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int FRAME_BITS = 11;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/parity_bit_calc.sv
// Combinational parity bit: even = XOR of data, odd = its inverse.
module parity_bit_calc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              mode_i,
    output logic              parity_o
);

    assign parity_o = (^data_i) ^ mode_i;

endmodule

// File: rtl/parity_serial_controller.sv
// Framed serial TX/RX (start, 8 data LSB first, parity, stop) with a
// saturating count of received frames that failed parity or stop checks.
module parity_serial_controller
    import parity_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 parity_mode,
    input  logic                 tx_valid,
    input  logic [DATA_W-1:0]    tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    input  logic                 rx_serial,
    output logic                 rx_valid,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    input  logic                 err_clear,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_W - 1);

    // ---------------- TX ----------------
    tx_state_t         tx_state_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_mode_q;
    logic [2:0]        tx_idx_q;
    logic              tx_ready_q;
    logic              tx_serial_q;
    logic              tx_par;
    logic [2:0]        tx_idx_nxt;

    assign tx_idx_nxt = tx_idx_q + 3'd1;

    parity_bit_calc #(.DATA_W(DATA_W)) u_tx_par (
        .data_i   (tx_data_q),
        .mode_i   (tx_mode_q),
        .parity_o (tx_par)
    );

    // Accept ignores bit_en so a byte can be latched the moment TX goes idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_data_q   <= '0;
            tx_mode_q   <= PARITY_EVEN;
            tx_idx_q    <= '0;
            tx_ready_q  <= 1'b1;
            tx_serial_q <= IDLE_LEVEL;
        end else begin
            case (tx_state_q)
                TX_IDLE: if (tx_valid) begin
                    tx_data_q   <= tx_data;
                    tx_mode_q   <= parity_mode;
                    tx_ready_q  <= 1'b0;
                    tx_serial_q <= START_LEVEL;
                    tx_state_q  <= TX_START;
                end
                TX_START: if (bit_en) begin
                    tx_idx_q    <= '0;
                    tx_serial_q <= tx_data_q[0];
                    tx_state_q  <= TX_DATA;
                end
                TX_DATA: if (bit_en) begin
                    if (tx_idx_q == LAST_IDX) begin
                        tx_serial_q <= tx_par;
                        tx_state_q  <= TX_PARITY;
                    end else begin
                        tx_idx_q    <= tx_idx_nxt;
                        tx_serial_q <= tx_data_q[tx_idx_nxt];
                    end
                end
                TX_PARITY: if (bit_en) begin
                    tx_serial_q <= STOP_LEVEL;
                    tx_state_q  <= TX_STOP;
                end
                TX_STOP: if (bit_en) begin
                    tx_serial_q <= IDLE_LEVEL;
                    tx_ready_q  <= 1'b1;
                    tx_state_q  <= TX_IDLE;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX ----------------
    rx_state_t         rx_state_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic              rx_mode_q;
    logic [2:0]        rx_idx_q;
    logic              rx_par_bit_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_perr_q;
    logic              rx_ferr_q;
    logic              rx_par;

    parity_bit_calc #(.DATA_W(DATA_W)) u_rx_par (
        .data_i   (rx_shift_q),
        .mode_i   (rx_mode_q),
        .parity_o (rx_par)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_shift_q   <= '0;
            rx_mode_q    <= PARITY_EVEN;
            rx_idx_q     <= '0;
            rx_par_bit_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: if (bit_en && rx_serial == START_LEVEL) begin
                    rx_mode_q  <= parity_mode;
                    rx_idx_q   <= '0;
                    rx_state_q <= RX_DATA;
                end
                RX_DATA: if (bit_en) begin
                    rx_shift_q <= {rx_serial, rx_shift_q[DATA_W-1:1]};
                    rx_idx_q   <= rx_idx_q + 3'd1;
                    if (rx_idx_q == LAST_IDX) rx_state_q <= RX_PARITY;
                end
                RX_PARITY: if (bit_en) begin
                    rx_par_bit_q <= rx_serial;
                    rx_state_q   <= RX_STOP;
                end
                RX_STOP: if (bit_en) begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= rx_shift_q;
                    rx_perr_q  <= (rx_par != rx_par_bit_q);
                    rx_ferr_q  <= (rx_serial != STOP_LEVEL);
                    rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- error counter ----------------
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clear)
            err_cnt_d = '0;
        else if (rx_valid_q && (rx_perr_q || rx_ferr_q) && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign tx_ready      = tx_ready_q;
    assign tx_busy       = !tx_ready_q;
    assign tx_serial     = tx_serial_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_parity_serial_controller.sv
// Bench for parity_serial_controller: frame-level reference model, RX vector table,
// randomized loopback/RX frames and hand-written stall/hold/reset sequences.
module tb_parity_serial_controller;

    localparam int ECW     = 2;
    localparam int CNT_MAX = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           bit_en = 1'b1;
    logic           parity_mode = 1'b0;
    logic           tx_valid = 1'b0;
    logic [7:0]     tx_data = 8'h00;
    logic           err_clear = 1'b0;
    logic           rx_drv = 1'b1;
    logic           loop_en = 1'b0;
    logic           rx_serial;
    logic           tx_ready, tx_serial, tx_busy;
    logic           rx_valid, rx_parity_err, rx_frame_err;
    logic [7:0]     rx_data;
    logic [ECW-1:0] err_count;

    int nchk = 0, nerr = 0;
    int ph = 0, per = 1;
    int cnt_m = 0;

    assign rx_serial = loop_en ? tx_serial : rx_drv;

    parity_serial_controller #(.DATA_W(8), .ERR_CNT_W(ECW)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .parity_mode(parity_mode),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_serial(tx_serial), .tx_busy(tx_busy), .rx_serial(rx_serial),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .err_clear(err_clear), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       m, pb, sb, clr;
        logic       ep, ef;
        int         ec;
    } rxvec_t;

    rxvec_t tbl[11];

    // Parity bit from the rules: even mode makes the total ones count even.
    function automatic logic par_of(input logic [7:0] d, input logic m);
        return logic'($countones(d) % 2) ^ m;
    endfunction

    // Transmission order: index 0 = start ... index 10 = stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic m);
        return {1'b1, par_of(d, m), d, 1'b0};
    endfunction

    function automatic int cnt_next(input int c, input logic clr, input logic bad);
        if (clr) return 0;
        if (bad) return (c >= CNT_MAX) ? CNT_MAX : c + 1;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1 >= per) ? 0 : ph + 1;
        bit_en = (ph == 0);
    endtask

    task automatic tx_frame(input logic [7:0] d, input logic m, input logic [10:0] exp, input bit lb);
        int  hold;
        bit  en;
        chk("tx_ready_idle", tx_ready, 1);
        tx_valid = 1'b1; tx_data = d; parity_mode = m;
        tick();
        tx_valid = 1'b0; tx_data = 8'($urandom);
        chk("tx_busy_frame", tx_busy, 1);
        chk("tx_ready_frame", tx_ready, 0);
        for (int b = 0; b < 11; b++) begin
            hold = 0; en = 1'b0;
            if (b == 1) parity_mode = ~m;
            while (!en && hold < 64) begin
                chk($sformatf("tx_bit%0d", b), tx_serial, exp[b]);
                if (lb) chk("rx_valid_early", rx_valid, 0);
                en = bit_en;
                hold++;
                tick();
            end
            if (b > 0 || per == 1) chk($sformatf("bit_hold%0d", b), hold, per);
        end
        chk("tx_ready_end", tx_ready, 1);
        chk("tx_busy_end", tx_busy, 0);
        if (lb) begin
            chk("lb_rx_valid", rx_valid, 1);
            chk("lb_rx_data", rx_data, d);
            chk("lb_parity_err", rx_parity_err, 0);
            chk("lb_frame_err", rx_frame_err, 0);
        end
        parity_mode = m;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic m, input logic pb, input logic sb,
                            input logic clr, input logic ep, input logic ef, input int ec);
        per = 1; ph = 0; bit_en = 1'b1;
        parity_mode = m; rx_drv = 1'b0;
        tick();
        parity_mode = logic'($urandom);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            chk("rx_valid_data", rx_valid, 0);
            tick();
        end
        rx_drv = pb; tick();
        rx_drv = sb; tick();
        rx_drv = 1'b1; err_clear = clr;
        chk("rx_valid", rx_valid, 1);
        chk("rx_data", rx_data, d);
        chk("rx_parity_err", rx_parity_err, ep);
        chk("rx_frame_err", rx_frame_err, ef);
        tick();
        err_clear = 1'b0;
        chk("rx_valid_pulse", rx_valid, 0);
        chk("err_count", err_count, ec);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc, last, nrx;
        logic [7:0] d;
        logic m, pb, sb, clr, ep, ef;

        //            d      m     pb    sb    clr   ep    ef   ec
        tbl[0]  = '{8'h7A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{8'h7A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[2]  = '{8'h7A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[3]  = '{8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[4]  = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3};
        tbl[5]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3};
        tbl[6]  = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3};
        tbl[7]  = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[8]  = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[9]  = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};

        // reset values
        tick(); tick();
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_serial", tx_serial, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_parity_err", rx_parity_err, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        chk("rst_err_count", err_count, 0);
        rst = 1'b0;
        tick();

        // directed TX frames, loopback on
        loop_en = 1'b1;
        tx_frame(8'hAA, 1'b0, 11'b10101010100, 1'b1);
        tx_frame(8'h7A, 1'b1, 11'b10011110100, 1'b1);
        tx_frame(8'h7A, 1'b0, 11'b11011110100, 1'b1);
        chk("lb_err_count", err_count, 0);

        // RX vector table, external line
        loop_en = 1'b0;
        tick();
        for (int i = 0; i < 11; i++)
            rx_frame(tbl[i].d, tbl[i].m, tbl[i].pb, tbl[i].sb, tbl[i].clr,
                     tbl[i].ep, tbl[i].ef, tbl[i].ec);
        cnt_m = tbl[10].ec;

        // randomized RX frames against the model
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom);
            m   = logic'($urandom);
            pb  = par_of(d, m) ^ ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            ep  = (pb != par_of(d, m));
            ef  = !sb;
            cnt_m = cnt_next(cnt_m, clr, ep || ef);
            rx_frame(d, m, pb, sb, clr, ep, ef, cnt_m);
        end

        // randomized loopback frames with varying bit-rate strobe
        loop_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            per = $urandom_range(1, 4);
            d = 8'($urandom);
            m = logic'($urandom);
            tx_frame(d, m, frame_of(d, m), 1'b1);
        end

        // stall: strobe every 4th cycle holds each bit 4 cycles
        per = 4;
        tx_frame(8'hAA, 1'b0, 11'b10101010100, 1'b1);

        // tx_valid held for 3 frames: accepts only when idle, 12 cycles apart
        per = 1; ph = 0; bit_en = 1'b1;
        tick();
        tx_valid = 1'b1; tx_data = 8'h3C; parity_mode = 1'b1;
        acc = 0; last = -1; nrx = 0;
        for (int c = 0; c < 48; c++) begin
            if (c == 36) tx_valid = 1'b0;
            if (tx_valid && tx_ready) begin acc++; last = c; end
            if (rx_valid) begin
                nrx++;
                chk("hold_rx_data", rx_data, 8'h3C);
                chk("hold_parity_err", rx_parity_err, 0);
            end
            tick();
        end
        chk("hold_accepts", acc, 3);
        chk("hold_last_accept", last, 24);
        chk("hold_rx_frames", nrx, 3);

        // reset during D3 aborts both sides
        tx_valid = 1'b1; tx_data = 8'h00; parity_mode = 1'b0;
        tick();
        tx_valid = 1'b0;
        repeat (4) tick();
        chk("pre_rst_d3", tx_serial, 0);
        rst = 1'b1;
        #1;
        chk("rst_async_serial", tx_serial, 1);
        chk("rst_async_ready", tx_ready, 1);
        tick(); tick();
        rst = 1'b0;
        nrx = 0;
        for (int c = 0; c < 20; c++) begin
            if (rx_valid) nrx++;
            tick();
        end
        chk("post_rst_no_rx", nrx, 0);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_err_count", err_count, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
